// File: rtl/dmem_readback.sv
// dmem_readback: dumps a contiguous word range of data memory over a valid/ready stream.
// Define DMEM_READBACK_CHECKSUM_EN to add a running checksum of the transferred words.
//
// state | meaning
// IDLE  | waiting for a start command
// READ  | issuing reads while the memory port is free and buffer credit allows
// DRAIN | every read issued; emptying the output buffer until the last word leaves
module dmem_readback #(
   parameter int DPW        = 32,
   parameter int CNTW       = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [DPW-1:0]  start_addr,
   input  logic [CNTW-1:0] word_count,
   input  logic            abort,
   input  logic            mem_busy,
   output logic            mem_re,
   output logic [DPW-1:0]  mem_raddr,
   input  logic [DPW-1:0]  mem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DPW-1:0]  out_data,
   output logic [DPW-1:0]  out_addr,
   output logic            out_last,
`ifdef DMEM_READBACK_CHECKSUM_EN
   output logic [DPW-1:0]  checksum,
`endif
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [DPW-1:0]  addr_q;
   logic [CNTW-1:0] remaining_q;
   logic            inflight_q;
   logic [DPW-1:0]  inflight_addr_q;
   logic            inflight_last_q;
   logic [DPW-1:0]  fifo_data [FIFO_DEPTH];
   logic [DPW-1:0]  fifo_addr [FIFO_DEPTH];
   logic            fifo_last [FIFO_DEPTH];
   logic            wr_ptr_q, rd_ptr_q;
   logic [1:0]      fifo_count_q;
   logic [2:0]      credit_used;
   logic            accept, zero_start, pop, head_last, done_q;

   assign accept     = start && (state_q == IDLE) && (word_count != '0);
   assign zero_start = start && (state_q == IDLE) && (word_count == '0);
   assign out_valid  = (fifo_count_q != 2'd0);
   assign pop        = out_valid && out_ready;
   assign head_last  = fifo_last[rd_ptr_q];
   assign out_data   = out_valid ? fifo_data[rd_ptr_q] : '0;
   assign out_addr   = out_valid ? fifo_addr[rd_ptr_q] : '0;
   assign out_last   = out_valid && head_last;
   assign mem_raddr  = mem_re ? addr_q : '0;
   assign done       = done_q;

   // Entries held or about to land after this cycle's pop; a new read needs a free slot.
   assign credit_used = 3'(fifo_count_q) + 3'(inflight_q) - 3'(pop);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (accept) state_d = READ;
         READ: begin
            if (abort)                                    state_d = IDLE;
            else if (mem_re && remaining_q == CNTW'(1))   state_d = DRAIN;
         end
         DRAIN: begin
            if (abort)                  state_d = IDLE;
            else if (pop && head_last)  state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_re = 1'b0;
      busy   = (state_q != IDLE);
      if (state_q == READ && !abort && !mem_busy && remaining_q != '0 &&
          credit_used < 3'(FIFO_DEPTH))
         mem_re = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         remaining_q <= '0;
      end else if (accept) begin
         addr_q      <= start_addr & ~DPW'(3);
         remaining_q <= word_count;
      end else if (mem_re) begin
         addr_q      <= addr_q + DPW'(4);
         remaining_q <= remaining_q - CNTW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_addr_q <= '0;
         inflight_last_q <= 1'b0;
      end else if (mem_re) begin
         inflight_addr_q <= addr_q;
         inflight_last_q <= (remaining_q == CNTW'(1));
      end
   end

   // Abort flushes the buffer and drops the read still returning from memory.
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         inflight_q   <= 1'b0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         fifo_count_q <= 2'd0;
      end else begin
         inflight_q   <= mem_re;
         if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
         if (pop)        rd_ptr_q <= ~rd_ptr_q;
         fifo_count_q <= fifo_count_q + 2'(inflight_q) - 2'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (inflight_q) begin
         fifo_data[wr_ptr_q] <= mem_rdata;
         fifo_addr[wr_ptr_q] <= inflight_addr_q;
         fifo_last[wr_ptr_q] <= inflight_last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= zero_start || (pop && head_last && !abort);
   end

`ifdef DMEM_READBACK_CHECKSUM_EN
   logic [DPW-1:0] sum_q;

   always_ff @(posedge clk) begin
      if (rst)                        sum_q <= '0;
      else if (accept || zero_start)  sum_q <= '0;
      else if (pop && !abort)         sum_q <= sum_q + out_data;
   end

   assign checksum = sum_q;
`endif

endmodule

// File: doc/dmem_readback.md
Name: dmem_readback

Overview:
- Read-side companion to the data-cache load port (data_en/input_data/input_addr).
- On command, scans a contiguous word range of data memory and streams each word out with its address over a valid/ready interface; used by benches and debug to dump memory after a program run.
- Sits beside the data memory and shares its read port with the pipeline; a pipeline store always has priority.

Parameters:
- DPW, 32, data/address width in bits (matches rv32i_pkg).
- CNTW, 16, width of the word-count field.
- FIFO_DEPTH, 2, output buffer entries; fixed at 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse.
- start_addr  in  DPW  byte address of first word; bits [1:0] forced to 0 on capture.
- word_count  in  CNTW  number of words to read.
- abort  in  1  cancel the current dump.
- mem_busy  in  1  pipeline owns memory this cycle (memwriteM); no read may issue.
- mem_re  out  1  read request.
- mem_raddr  out  DPW  read address.
- mem_rdata  in  DPW  read data, valid exactly one cycle after mem_re.
- out_valid  out  1  stream word available.
- out_ready  in  1  consumer accepts.
- out_data  out  DPW  word read.
- out_addr  out  DPW  address of out_data.
- out_last  out  1  final word of the dump.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse when the last word is transferred.

Behaviour:
- Reset values: all outputs 0; FSM IDLE; FIFO empty; in-flight flag clear; counters 0.
- Reset mid-operation: the in-flight read return is discarded; no done pulse.
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - start with word_count>0 captures the address and count, sets busy, and enters READ next cycle.
  - start with word_count==0 leaves the FSM in IDLE and pulses done the next cycle; busy stays 0.
  - start is ignored in any state other than IDLE.
- READ: mem_re=1 when all of the following hold:
  - mem_busy==0.
  - remaining>0.
  - (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready.
- On each issue: mem_raddr = current address, address += 4 (wraps modulo 2^DPW), remaining −= 1.
- When the last read issues, move to DRAIN.
- mem_rdata is written into the FIFO in the cycle after issue, together with its address and a last flag (set when remaining was 1 at issue).
- DRAIN: on transfer of the entry with out_last=1, pulse done, clear busy, go to IDLE.
- Output side:
  - out_valid = FIFO non-empty; out_data, out_addr and out_last come from the FIFO head.
  - Head fields stay stable while out_valid & !out_ready.
- Latency and throughput:
  - start sampled in cycle 0; first mem_re in cycle 1; first out_valid in cycle 3.
  - With out_ready=1 and mem_busy=0, one word per cycle.
- Simultaneous push and pop on a full FIFO is legal; the FIFO never overflows (credit rule above).
- abort (any state, priority below rst): next cycle the FSM is in IDLE, FIFO is flushed, the in-flight return is dropped, busy=0, and no done pulse. abort in IDLE has no effect.

Optional Feature:
- Macro: DMEM_READBACK_CHECKSUM_EN.
- Defined:
  - Adds output checksum[DPW-1:0], a modular sum of all transferred out_data.
  - Cleared when start is accepted; valid and held from the done pulse until the next accepted start.
  - Reset value 0.
- Undefined: no checksum port or logic; all other behaviour identical.

Test Plan:
- Load mem[0x100..0x10C] = 0x11,0x22,0x33,0x44 via the load port; start_addr=0x100, word_count=4, out_ready=1. Required:
  - out_data 0x11,0x22,0x33,0x44 on consecutive cycles 3–6, with out_addr 0x100..0x10C.
  - out_last only on 0x44; done in the cycle after that transfer.
  - checksum=0xAA when enabled.
- Same dump with out_ready low for 5 cycles starting at cycle 4 → out_data held at 0x22, no more than 2 words buffered, no word lost or duplicated, done after the 4th transfer.
- mem_busy held high for cycles 1–3 → no mem_re in those cycles; first mem_re in cycle 4; data order unchanged.
- start_addr=0x103 → captured as 0x100. start_addr=0xFFFFFFFC with word_count=2 → out_addr 0xFFFFFFFC, then 0x00000000.
- word_count=0 → done pulse in cycle 1, busy never high, mem_re never high. A second start while busy is ignored.
- abort asserted in cycle 4 of an 8-word dump → busy=0 and out_valid=0 from cycle 5, no done pulse. rst asserted mid-dump → all outputs 0 in the next cycle.
